// File: rtl/riscv_types.sv
// Shared RISC-V type definitions: RV32M funct3 encodings and multiply/divide FSM states.
package riscv_types;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: shift-add on {acc_hi, multiplier}. Divide: restoring step on {rem, dividend/quotient}.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            q_bit;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        // Trial compare is XLEN+1 wide; the difference always fits XLEN bits when it is kept.
        q_bit    = (shifted >= {1'b0, operand});
        diff     = shifted[XLEN-1:0] - operand;
        if (is_div) begin
            acc_next = {(q_bit ? diff : shifted[XLEN-1:0]), acc[XLEN-2:0], q_bit};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, valid/ready in and out,
// divide-by-zero and signed-overflow short-circuit at accept, flush to abort.
module mdu_iterative
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state, state_next;
    mdu_op_t           op_q;
    logic              neg1, neg2;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc, acc_next, prod_fix;
    logic [CW-1:0]     count;

    logic              accept, n1, n2, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag1, mag2, fast_result, final_result, quo, rem;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        n1          = (op inside {MULH, MULHSU, DIV, REM}) && op1[XLEN-1];
        n2          = (op inside {MULH, DIV, REM}) && op2[XLEN-1];
        mag1        = n1 ? -op1 : op1;
        mag2        = n2 ? -op2 : op2;
        div_zero    = op_is_div(op) && (op2 == '0);
        div_ovf     = (op == DIV || op == REM) && (op1 == INT_MIN) && (op2 == '1);
        fast        = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero) fast_result = op[1] ? op1 : '1;
        else          fast_result = op[1] ? '0 : op1;
    end

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix = (neg1 ^ neg2) ? -acc_next : acc_next;
        quo      = acc_next[XLEN-1:0];
        rem      = acc_next[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                  final_result = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
            DIV:                  final_result = (neg1 ^ neg2) ? -quo : quo;
            REM:                  final_result = neg1 ? -rem : rem;
            DIVU:                 final_result = quo;
            default:              final_result = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? DONE : CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            op_q    <= MUL;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_next;
            if (!flush) begin
                case (state)
                    IDLE: if (accept) begin
                        op_q  <= op;
                        neg1  <= n1;
                        neg2  <= n2;
                        count <= '0;
                        if (fast) begin
                            result <= fast_result;
                        end else if (op_is_div(op)) begin
                            acc     <= {{XLEN{1'b0}}, mag1};
                            operand <= mag2;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, mag2};
                            operand <= mag1;
                        end
                    end
                    CALC: begin
                        acc   <= acc_next;
                        count <= count + CW'(1);
                        if (count == LAST) result <= final_result;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed RV32M vectors, backpressure, flush, reset,
// then randomized operations checked against a plain-arithmetic reference model.
module tb_mdu_iterative;
    import riscv_types::*;

    localparam int XLEN = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    mdu_op_t     op;
    logic [31:0] op1, op2, result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        mdu_op_t     o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (o)
            MUL:    r = sa * sb;
            MULH:   r = (sa * sb) >>> 32;
            MULHSU: r = (sa * ub) >>> 32;
            MULHU:  r = longint'(64'(ua * ub) >> 32);
            DIV:    r = (b == 0) ? -1 : (a == INT_MIN && b == '1) ? sa : sa / sb;
            DIVU:   r = (b == 0) ? -1 : ua / ub;
            REM:    r = (b == 0) ? sa : (a == INT_MIN && b == '1) ? 0 : sa % sb;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return INT_MIN;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_monitor();
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got result 0x%08h, expected no output", result);
                end else begin
                    check("sb_result", result, exp_q.pop_front());
                end
            end
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("wait_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        wait_ready();
        op = o; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, k;
        bit saw_valid;
        mdu_op_t o;
        logic [31:0] a, b;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = MUL; op1 = '0; op2 = '0;
        fork
            run_monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        // MUL with exact timing: out_valid 32 edges after accept, in_ready back after the handshake.
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        check("calc_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("calc_busy", {31'b0, busy}, 32'd1);
        wait_valid(lat);
        check("mul_latency", 32'(lat), 32'd32);
        @(posedge clk); #1;
        check("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
        check("out_valid_after_hs", {31'b0, out_valid}, 32'd0);

        vecs.push_back('{MULH,   INT_MIN,       INT_MIN,       32'h4000_0000, 32});
        vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32});
        vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32});
        vecs.push_back('{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32});
        vecs.push_back('{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32});
        vecs.push_back('{DIVU,   32'd100,       32'd7,         32'd14,        32});
        vecs.push_back('{REMU,   32'd100,       32'd7,         32'd2,         32});
        vecs.push_back('{DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 0});
        vecs.push_back('{REMU,   32'd5,         32'd0,         32'd5,         0});
        vecs.push_back('{DIV,    INT_MIN,       32'hFFFF_FFFF, INT_MIN,       0});
        vecs.push_back('{REM,    INT_MIN,       32'hFFFF_FFFF, 32'd0,         0});
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].e);
            wait_valid(lat);
            check($sformatf("latency_%s", vecs[i].o.name()), 32'(lat), 32'(vecs[i].lat));
            @(posedge clk); #1;
        end

        // Backpressure: five stalled cycles with a competing request, handshake on the sixth.
        out_ready = 1'b0;
        issue(DIVU, 32'd100, 32'd7, 32'd14);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd32);
        op = MUL; op1 = 32'd3; op2 = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_result_hold", result, 32'd14);
            check("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_sixth_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_no_extra_op", {31'b0, busy}, 32'd0);
        check("bp_sb_drained", 32'(exp_q.size()), 32'd0);

        // Flush in the 10th CALC cycle.
        issue(MUL, 32'h0001_2345, 32'h0000_0777, ref_model(MUL, 32'h0001_2345, 32'h0000_0777));
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_result_kept", result, 32'd14);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush_no_output", {31'b0, saw_valid}, 32'd0);
        issue(MUL, 32'd3, 32'd4, 32'd12);
        wait_valid(lat);
        check("post_flush_latency", 32'(lat), 32'd32);
        @(posedge clk); #1;

        // Reset in the 20th CALC cycle.
        issue(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, ref_model(MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        rst = 1'b0;

        // Randomized operations with random output stalls.
        for (int i = 0; i < 200; i++) begin
            o = mdu_op_t'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            issue(o, a, b, ref_model(o, a, b));
            wait_valid(lat);
            if ((o[2] && b == 0) || ((o == DIV || o == REM) && a == INT_MIN && b == '1))
                check("rand_latency_fast", 32'(lat), 32'd0);
            else
                check("rand_latency", 32'(lat), 32'd32);
            k = $urandom_range(0, 3);
            if (k > 0) begin
                out_ready = 1'b0;
                repeat (k) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end

        repeat (2) begin @(posedge clk); #1; end
        check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
